// File: rtl/video_timing_pattern_gen.sv
// video_timing_pattern_gen
//
// Parametrised raster timing generator with a built-in test-pattern source.
// The horizontal and vertical counters walk the full raster (active, front
// porch, sync, back porch). Every output is a register loaded from the
// current counter state, so RGB, DE and both syncs share one clock of latency.
//
// Ports:
//   i_clk        pixel clock (single clock domain)
//   i_rst        synchronous reset, active-high
//   i_en         count enable; while low all counters and outputs hold
//   i_mode       pattern select, taken at the first pixel of each frame
//   i_solid_rgb  {R,G,B} colour for mode 0
//   o_red_data / o_gre_data / o_blu_data  pixel colour, zero outside DE
//   o_h_sync / o_v_sync                   syncs, asserted level HS_POL/VS_POL
//   o_data_en                             active-video flag
//   o_frame_cnt                           completed frames, wraps at 2^16
module video_timing_pattern_gen #(
  parameter int   H_ACTIVE = 1024,
  parameter int   H_FP     = 24,
  parameter int   H_SYNC   = 136,
  parameter int   H_BP     = 160,
  parameter int   V_ACTIVE = 768,
  parameter int   V_FP     = 3,
  parameter int   V_SYNC   = 6,
  parameter int   V_BP     = 29,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   CHK_LOG2 = 5,
  parameter int   BOX_SIZE = 64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  input  logic [2:0]  i_mode,
  input  logic [23:0] i_solid_rgb,
  output logic [7:0]  o_red_data,
  output logic [7:0]  o_gre_data,
  output logic [7:0]  o_blu_data,
  output logic        o_h_sync,
  output logic        o_v_sync,
  output logic        o_data_en,
  output logic [15:0] o_frame_cnt
);

  localparam int CW = 16;

  localparam logic [CW-1:0] H_LAST    = CW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CW-1:0] V_LAST    = CW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CW-1:0] H_ACT     = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT     = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END    = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END    = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] BAR_LAST  = CW'(H_ACTIVE / 8 - 1);
  localparam logic [CW-1:0] BOX_W     = CW'(BOX_SIZE);
  localparam logic [23:0]   WHITE     = 24'hFFFFFF;

  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;
  logic [CW-1:0] bar_pos;
  logic [2:0]    bar_idx;
  logic [2:0]    mode;

  logic          h_last;
  logic          v_last;
  logic          frame_start;
  logic          frame_end;
  logic [2:0]    mode_now;
  logic          de_now;
  logic          hs_now;
  logic          vs_now;
  logic [1:0]    box_hit;
  logic [1:0][CW-1:0] axis_cnt;
  logic [23:0]   bar_rgb;
  logic [23:0]   rgb_now;

  assign h_last      = (h_cnt == H_LAST);
  assign v_last      = (v_cnt == V_LAST);
  assign frame_start = (h_cnt == '0) && (v_cnt == '0);
  assign frame_end   = h_last && v_last;

  // The latched mode only updates on the first pixel of a frame; that pixel
  // itself must already show the new pattern, so bypass the register there.
  assign mode_now = frame_start ? i_mode : mode;

  assign de_now = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs_now = (h_cnt >= HS_START) && (h_cnt < HS_END);
  // v_cnt only moves on the h_cnt wrap, so v_sync naturally changes at h_cnt=0.
  assign vs_now = (v_cnt >= VS_START) && (v_cnt < VS_END);

  assign axis_cnt = {v_cnt, h_cnt};

  // Moving box: one bouncing position per axis (0 = x, 1 = y). Each position
  // steps once per frame and flips direction on touching either limit.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_box
      localparam logic [CW-1:0] LIM = (gi == 0) ? CW'(H_ACTIVE - BOX_SIZE)
                                                : CW'(V_ACTIVE - BOX_SIZE);
      logic [CW-1:0] pos;
      logic          dir_up;
      logic [CW-1:0] step;

      assign step = dir_up ? pos + 1'b1 : pos - 1'b1;
      assign box_hit[gi] = (axis_cnt[gi] >= pos) && (axis_cnt[gi] < pos + BOX_W);

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          pos    <= '0;
          dir_up <= 1'b1;
        end else if (i_en && frame_end) begin
          pos <= step;
          if (step == LIM) begin
            dir_up <= 1'b0;
          end else if (step == '0) begin
            dir_up <= 1'b1;
          end
        end
      end
    end
  endgenerate

  always_comb begin
    bar_rgb = 24'h000000;
    case (bar_idx)
      3'd0:    bar_rgb = 24'hFFFFFF;
      3'd1:    bar_rgb = 24'hFFFF00;
      3'd2:    bar_rgb = 24'h00FFFF;
      3'd3:    bar_rgb = 24'h00FF00;
      3'd4:    bar_rgb = 24'hFF00FF;
      3'd5:    bar_rgb = 24'hFF0000;
      3'd6:    bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
  end

  always_comb begin
    rgb_now = 24'h000000;
    case (mode_now)
      3'd0:    rgb_now = i_solid_rgb;
      3'd1:    rgb_now = bar_rgb;
      3'd2:    rgb_now = {h_cnt[7:0], h_cnt[7:0], h_cnt[7:0]};
      3'd3:    rgb_now = (h_cnt[CHK_LOG2] ^ v_cnt[CHK_LOG2]) ? WHITE : 24'h000000;
      3'd4:    rgb_now = (&box_hit) ? WHITE : 24'h000000;
      default: rgb_now = 24'h000000;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      bar_pos     <= '0;
      bar_idx     <= '0;
      mode        <= '0;
      o_frame_cnt <= '0;
      o_data_en   <= 1'b0;
      o_red_data  <= '0;
      o_gre_data  <= '0;
      o_blu_data  <= '0;
      o_h_sync    <= ~HS_POL;
      o_v_sync    <= ~VS_POL;
    end else if (i_en) begin
      h_cnt <= h_last ? '0 : h_cnt + 1'b1;
      if (h_last) begin
        v_cnt <= v_last ? '0 : v_cnt + 1'b1;
      end
      if (frame_end) begin
        o_frame_cnt <= o_frame_cnt + 1'b1;
      end
      if (frame_start) begin
        mode <= i_mode;
      end

      // Bar index tracks h_cnt by counting bar widths instead of dividing.
      // It wraps harmlessly past the active region, where DE masks it.
      if (h_last) begin
        bar_pos <= '0;
        bar_idx <= '0;
      end else if (bar_pos == BAR_LAST) begin
        bar_pos <= '0;
        bar_idx <= bar_idx + 1'b1;
      end else begin
        bar_pos <= bar_pos + 1'b1;
      end

      o_data_en  <= de_now;
      o_red_data <= de_now ? rgb_now[23:16] : 8'h00;
      o_gre_data <= de_now ? rgb_now[15:8]  : 8'h00;
      o_blu_data <= de_now ? rgb_now[7:0]   : 8'h00;
      o_h_sync   <= hs_now ? HS_POL : ~HS_POL;
      o_v_sync   <= vs_now ? VS_POL : ~VS_POL;
    end
  end

endmodule

// File: tb/tb_video_timing_pattern_gen.sv
// Testbench for video_timing_pattern_gen using a small raster so many frames
// fit in a short run. A reference model derives every output from the number
// of enabled clocks since reset (position = count mod frame size), so stalls
// via i_en are checked against the uninterrupted raster sequence.
module tb_video_timing_pattern_gen;

  localparam int   HA = 24, HFP = 2, HSW = 3, HBP = 3;
  localparam int   VA = 12, VFP = 1, VSW = 2, VBP = 1;
  localparam int   HT = HA + HFP + HSW + HBP;   // 32
  localparam int   VT = VA + VFP + VSW + VBP;   // 16
  localparam int   FRAME = HT * VT;             // 512
  localparam int   CHK = 2;
  localparam int   BOX = 6;
  localparam logic HSP = 1'b1;
  localparam logic VSP = 1'b0;

  logic        clk;
  logic        rst;
  logic        en;
  logic [2:0]  mode;
  logic [23:0] solid;
  logic [7:0]  red, gre, blu;
  logic        hs, vs, de;
  logic [15:0] fc;

  video_timing_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(HSP), .VS_POL(VSP), .CHK_LOG2(CHK), .BOX_SIZE(BOX)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_mode(mode), .i_solid_rgb(solid),
    .o_red_data(red), .o_gre_data(gre), .o_blu_data(blu),
    .o_h_sync(hs), .o_v_sync(vs), .o_data_en(de), .o_frame_cnt(fc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Triangle wave: position after f frames bouncing between 0 and lim.
  function automatic int bounce(int f, int lim);
    int t;
    t = f % (2 * lim);
    return (t <= lim) ? t : 2 * lim - t;
  endfunction

  function automatic logic [23:0] bar_color(int i);
    case (i)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic [23:0] pixel(logic [2:0] m, int x, int y, int f, logic [23:0] s);
    int bx, by;
    logic [7:0] g;
    g  = x[7:0];
    bx = bounce(f, HA - BOX);
    by = bounce(f, VA - BOX);
    case (m)
      3'd0: return s;
      3'd1: return bar_color(x / (HA / 8));
      3'd2: return {g, g, g};
      3'd3: return ((((x >> CHK) ^ (y >> CHK)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
      3'd4: return (x >= bx && x < bx + BOX && y >= by && y < by + BOX) ? 24'hFFFFFF : 24'h000000;
      default: return 24'h000000;
    endcase
  endfunction

  task automatic chk_lit(string name, logic [31:0] act, logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Reference model state, advanced at each active clock edge.
  int          n;
  int          mp, mx, my, mf;
  int          last_n, last_x, last_y, last_f;
  logic [2:0]  cur_mode;
  logic [2:0]  last_mode;
  logic        exp_de, exp_hs, exp_vs;
  logic [23:0] exp_rgb;
  logic [15:0] exp_fc;
  logic        rst_edge = 1'b0;
  logic        fresh = 1'b0;
  logic        checking = 1'b0;
  logic        pinned = 1'b0;

  always @(posedge clk) begin
    rst_edge = rst;
    fresh    = !rst && en;
    if (rst) begin
      n        = 0;
      cur_mode = 3'd0;
      exp_de   = 1'b0;
      exp_rgb  = 24'h0;
      exp_hs   = ~HSP;
      exp_vs   = ~VSP;
      exp_fc   = 16'd0;
    end else if (en) begin
      mp = n % FRAME;
      mx = mp % HT;
      my = mp / HT;
      mf = n / FRAME;
      if (mp == 0) cur_mode = mode;
      exp_de  = (mx < HA) && (my < VA);
      exp_rgb = exp_de ? pixel(cur_mode, mx, my, mf, solid) : 24'h0;
      exp_hs  = (mx >= HA + HFP && mx < HA + HFP + HSW) ? HSP : ~HSP;
      exp_vs  = (my >= VA + VFP && my < VA + VFP + VSW) ? VSP : ~VSP;
      exp_fc  = 16'((n + 1) / FRAME);
      last_n = n; last_x = mx; last_y = my; last_f = mf; last_mode = cur_mode;
      n++;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      if (!pinned) begin
        pinned = 1'b1;
        chk_lit("model_bounce_f19", 32'(bounce(19, 18)), 32'd17);
        chk_lit("model_bounce_f36", 32'(bounce(36, 18)), 32'd0);
        chk_lit("model_bar1", 32'(bar_color(1)), 32'hFFFF00);
      end

      tests++;
      if ({de, hs, vs, red, gre, blu, fc} !== {exp_de, exp_hs, exp_vs, exp_rgb, exp_fc}) begin
        fails++;
        $display("FAIL cycle t=%0t pix(%0d,%0d) f%0d: got de=%b hs=%b vs=%b rgb=%h fc=%0d, required de=%b hs=%b vs=%b rgb=%h fc=%0d",
                 $time, last_x, last_y, last_f, de, hs, vs, {red, gre, blu}, fc,
                 exp_de, exp_hs, exp_vs, exp_rgb, exp_fc);
      end

      if (rst_edge) begin
        chk_lit("rst_de",  32'(de), 32'd0);
        chk_lit("rst_rgb", 32'({red, gre, blu}), 32'd0);
        chk_lit("rst_hs",  32'(hs), 32'd0);
        chk_lit("rst_vs",  32'(vs), 32'd1);
        chk_lit("rst_fc",  32'(fc), 32'd0);
      end

      if (fresh) begin
        if (last_n == 0) begin
          chk_lit("first_pix_de", 32'(de), 32'd1);
          chk_lit("first_pix_fc", 32'(fc), 32'd0);
        end
        if (last_n == 2 * FRAME - 1) chk_lit("fc_after_two_frames", 32'(fc), 32'd2);
        case (last_mode)
          3'd1: if (last_y == 0) begin
            if (last_x == 0)  chk_lit("bar_x0",  32'({red, gre, blu}), 32'hFFFFFF);
            if (last_x == 3)  chk_lit("bar_x3",  32'({red, gre, blu}), 32'hFFFF00);
            if (last_x == 23) chk_lit("bar_x23", 32'({red, gre, blu}), 32'h000000);
            if (last_x == HA) chk_lit("bar_blank", 32'({red, gre, blu}), 32'h000000);
          end
          3'd3: begin
            if (last_x == 4 && last_y == 0) chk_lit("chk_4_0", 32'({red, gre, blu}), 32'hFFFFFF);
            if (last_x == 4 && last_y == 4) chk_lit("chk_4_4", 32'({red, gre, blu}), 32'h000000);
          end
          3'd4: begin
            if (last_f == 0 && last_x == 0 && last_y == 0)   chk_lit("box_f0_0_0", 32'({red, gre, blu}), 32'hFFFFFF);
            if (last_f == 1 && last_x == 0 && last_y == 0)   chk_lit("box_f1_0_0", 32'({red, gre, blu}), 32'h000000);
            if (last_f == 1 && last_x == 1 && last_y == 1)   chk_lit("box_f1_1_1", 32'({red, gre, blu}), 32'hFFFFFF);
            if (last_f == 7 && last_x == 7 && last_y == 5)   chk_lit("box_f7_7_5", 32'({red, gre, blu}), 32'hFFFFFF);
            if (last_f == 7 && last_x == 7 && last_y == 11)  chk_lit("box_f7_7_11", 32'({red, gre, blu}), 32'h000000);
            if (last_f == 18 && last_x == 18 && last_y == 6) chk_lit("box_f18_18_6", 32'({red, gre, blu}), 32'hFFFFFF);
            if (last_f == 18 && last_x == 17 && last_y == 6) chk_lit("box_f18_17_6", 32'({red, gre, blu}), 32'h000000);
            if (last_f == 19 && last_x == 22 && last_y == 5) chk_lit("box_f19_22_5", 32'({red, gre, blu}), 32'hFFFFFF);
            if (last_f == 19 && last_x == 23 && last_y == 5) chk_lit("box_f19_23_5", 32'({red, gre, blu}), 32'h000000);
          end
          default: ;
        endcase
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    en    = 1'b1;
    mode  = 3'd1;
    solid = 24'h000000;
    repeat (2) @(negedge clk);
    checking = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Two full frames of colour bars with the enable held high.
    repeat (2 * FRAME) @(negedge clk);

    // Solid colour frame; switch to checkerboard at line 5 of that frame.
    mode  = 3'd0;
    solid = 24'h123456;
    repeat (5 * HT) @(negedge clk);
    mode = 3'd3;
    repeat (2 * FRAME - 5 * HT) @(negedge clk);

    // Moving box for about 40 frames with a randomly stalling enable.
    mode = 3'd4;
    do_reset();
    for (int i = 0; i < 28000; i++) begin
      @(negedge clk);
      en    = ($urandom % 4) != 0;
      solid = $urandom;
    end
    en = 1'b1;

    // Reset pulse in the middle of a line.
    mode = 3'd1;
    do_reset();
    repeat (200) @(negedge clk);
    do_reset();

    // Random modes, colours and stalls.
    for (int i = 0; i < 13000; i++) begin
      @(negedge clk);
      en    = ($urandom % 5) != 0;
      solid = $urandom;
      if ($urandom_range(0, 149) == 0) mode = 3'($urandom_range(0, 7));
    end

    en = 1'b1;
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
